// File: rtl/pipe_skid.sv
// pipe_skid: two-entry valid/ready elastic pipeline stage (main + skid register), full throughput,
// no combinational out_ready->in_ready path. Define PIPE_SKID_STALL_CNT_EN to add the stall_cnt output.
module pipe_skid #(
    parameter int unsigned      width      = 32,
    parameter logic [width-1:0] flush_data = {width{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [width-1:0] main_q, main_nxt;
    logic [width-1:0] skid_q, skid_nxt;

    // Handshake outputs decode registered state only, so out_ready never reaches in_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= flush_data;
            skid_q <= flush_data;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            // Squash wins over everything; a concurrent offer is simply dropped.
            state_nxt = EMPTY;
            main_nxt  = flush_data;
            skid_nxt  = flush_data;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_valid) begin
                        main_nxt  = in_data;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (in_valid && out_ready) begin
                        main_nxt = in_data;
                    end else if (in_valid) begin
                        skid_nxt  = in_data;
                        state_nxt = FULL;
                    end else if (out_ready) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        main_nxt  = skid_q;
                        state_nxt = ONE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    // Saturating count of cycles where the head is offered but refused; flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_state_legal: assert property (@(posedge clk) disable iff (rst)
        state inside {EMPTY, ONE, FULL});

    a_head_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));
`endif

endmodule

// File: tb/tb_pipe_skid.sv
// Bench for pipe_skid: directed scenarios plus randomized traffic against a 2-deep queue model.
module tb_pipe_skid;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [31:0]  stall_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference: items held by the stage, in FIFO order, capacity two.
    logic [W-1:0] mq[$];
    logic [W-1:0] mlog[$];
    logic [W-1:0] dlog[$];

    pipe_skid #(.width(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance one edge: update the model and log what the DUT hands downstream.
    task automatic tick();
        bit up, dn;
        up = in_valid && (mq.size() < 2);
        dn = out_ready && (mq.size() > 0);
        if (!rst && out_valid && out_ready) dlog.push_back(out_data);
        if (!rst && dn) mlog.push_back(mq[0]);
        @(posedge clk);
        if (!rst) begin
            if (flush) mq.delete();
            else begin
                if (dn) void'(mq.pop_front());
                if (up) mq.push_back(in_data);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        mq.delete();
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++; if (out_valid !== 1'b0) $display("FAIL idle_out_valid[%0d]: got %b want 0", i, out_valid); else n_pass++;
            n_total++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready[%0d]: got %b want 1", i, in_ready); else n_pass++;
            n_total++; if (out_data !== '0) $display("FAIL idle_out_data[%0d]: got %h want 0", i, out_data); else n_pass++;
        end
    endtask

    task automatic test_streaming();
        dlog.delete();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            tick();
            n_total++; if (out_valid !== 1'b1) $display("FAIL stream_out_valid[%0d]: got %b want 1", i, out_valid); else n_pass++;
            n_total++; if (out_data !== W'(i)) $display("FAIL stream_out_data[%0d]: got %h want %h", i, out_data, W'(i)); else n_pass++;
            n_total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); else n_pass++;
        end
        in_valid = 1'b0;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL stream_drain_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (dlog.size() != 4) $display("FAIL stream_count: got %0d want 4", dlog.size()); else n_pass++;
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] exp[3];
        exp[0] = 'hA; exp[1] = 'hB; exp[2] = 'hC;
        dlog.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 'hA;
        tick();
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_one: got %b want 1", in_ready); else n_pass++;
        in_data = 'hB;
        tick();
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full: got %b want 0", in_ready); else n_pass++;
        in_data = 'hC;
        tick();
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_hold: got %b want 0", in_ready); else n_pass++;
        n_total++; if (out_data !== W'('hA)) $display("FAIL bp_head_hold: got %h want a", out_data); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_total++; if (out_data !== W'('hB)) $display("FAIL bp_head_b: got %h want b", out_data); else n_pass++;
        tick();
        n_total++; if (out_data !== W'('hC)) $display("FAIL bp_head_c: got %h want c", out_data); else n_pass++;
        in_valid = 1'b0;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL bp_drain_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (dlog.size() != 3) $display("FAIL bp_count: got %0d want 3", dlog.size()); else n_pass++;
        for (int i = 0; i < 3 && i < dlog.size(); i++) begin
            n_total++; if (dlog[i] !== exp[i]) $display("FAIL bp_order[%0d]: got %h want %h", i, dlog[i], exp[i]); else n_pass++;
        end
    endtask

    task automatic test_flush();
        dlog.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 'h11;
        tick();
        in_data = 'h22;
        tick();
        n_total++; if (in_ready !== 1'b0) $display("FAIL flush_pre_full: got %b want 0", in_ready); else n_pass++;
        flush   = 1'b1;
        in_data = 'h33;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL flush_out_data: got %h want 0", out_data); else n_pass++;
        out_ready = 1'b1;
        repeat (3) tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_after_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (dlog.size() != 0) $display("FAIL flush_leak: got %0d items want 0", dlog.size()); else n_pass++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 'h51;
        tick();
        in_data = 'h52;
        tick();
        n_total++; if (in_ready !== 1'b0) $display("FAIL arst_pre_full: got %b want 0", in_ready); else n_pass++;
        #2 rst = 1'b1;
        #1;
        mq.delete();
        n_total++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL arst_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL arst_out_data: got %h want 0", out_data); else n_pass++;
        in_data = 'h53;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL arst_no_xfer: got %b want 0", out_valid); else n_pass++;
        #2 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = W'('h60 + i);
            tick();
            n_total++; if (out_data !== W'('h60 + i)) $display("FAIL arst_resume[%0d]: got %h want %h", i, out_data, W'('h60 + i)); else n_pass++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int errs;
        mlog.delete();
        dlog.delete();
        for (int c = 0; c < 400; c++) begin
            // An offer refused last cycle must be held unchanged.
            if (!(in_valid && mq.size() == 2)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = W'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            tick();
            n_total++; if (in_ready !== (mq.size() < 2)) $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, in_ready, mq.size() < 2); else n_pass++;
            n_total++; if (out_valid !== (mq.size() > 0)) $display("FAIL rnd_out_valid[%0d]: got %b want %b", c, out_valid, mq.size() > 0); else n_pass++;
            if (mq.size() > 0) begin
                n_total++; if (out_data !== mq[0]) $display("FAIL rnd_out_data[%0d]: got %h want %h", c, out_data, mq[0]); else n_pass++;
            end
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        n_total++; if (dlog.size() != mlog.size()) $display("FAIL rnd_count: got %0d want %0d", dlog.size(), mlog.size()); else n_pass++;
        errs = 0;
        for (int i = 0; i < dlog.size() && i < mlog.size(); i++)
            if (dlog[i] !== mlog[i]) errs++;
        n_total++; if (errs != 0) $display("FAIL rnd_order: got %0d mismatched items want 0", errs); else n_pass++;
    endtask

`ifdef PIPE_SKID_STALL_CNT_EN
    task automatic test_stall_cnt();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        mq.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 'h77;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        n_total++; if (stall_cnt !== 32'd7) $display("FAIL stall_count: got %0d want 7", stall_cnt); else n_pass++;
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();
        n_total++; if (stall_cnt !== 32'd7) $display("FAIL stall_flush: got %0d want 7", stall_cnt); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (stall_cnt !== 32'd0) $display("FAIL stall_reset: got %0d want 0", stall_cnt); else n_pass++;
        rst = 1'b0;
        mq.delete();
    endtask
`endif

    initial begin
        #12 rst = 1'b0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_random();
`ifdef PIPE_SKID_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
